ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave.sv | 154 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-port word array with programmable wait states,
// two-cycle ERROR response for illegal transfers and per-lane byte writes.
module ahb_sram_slave #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        dp_valid;
    logic        dp_write;
    logic [2:0]  dp_size;
    logic [31:0] dp_addr;
    logic [31:0] mem [MEM_WORDS];

    logic          ready_int;
    logic          accept;
    logic          ap_err;
    logic          complete;
    logic          mem_we;
    logic [3:0]    lane_en;
    logic [AW-1:0] dp_word;
    logic          unused_ok;

    // ERR2 already shows HREADYOUT=1, so a pipelined address phase is taken there too
    assign ready_int = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept    = HSEL && HREADY && HTRANS[1] && ready_int;
    assign ap_err    = (HSIZE > 3'b010)
                     || (HSIZE == 3'b001 && HADDR[0])
                     || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                     || (32'(HADDR[31:2]) >= 32'(MEM_WORDS));
    assign complete  = (state == ST_IDLE) && dp_valid;
    assign mem_we    = complete && dp_write && !reset;
    assign dp_word   = dp_addr[AW+1:2];
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, dp_addr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (ap_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Array read is combinational, so a write completing in the previous
    // cycle is already visible to the following read: forwarding comes free.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: begin
                if (dp_valid && !dp_write) begin
                    HRDATA = mem[dp_word];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= '0;
            dp_addr  <= '0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : '0;
            if (accept) begin
                dp_valid <= !ap_err;
                dp_write <= HWRITE;
                dp_size  <= HSIZE;
                dp_addr  <= HADDR;
            end else if (complete) begin
                dp_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        lane_en = '0;
        case (dp_size)
            3'b000:  lane_en[dp_addr[1:0]] = 1'b1;
            3'b001:  lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 1 and 3 wait states)
// share one bus; sel picks which one is addressed and observed.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    int unsigned sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata [3];
    logic        hrdyo  [3];
    logic        hresp  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .HSEL(hsel && sel == 0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000),
        .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hrdyo[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hrdyo[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .HSEL(hsel && sel == 1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000),
        .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hrdyo[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hrdyo[1]), .HRESP(hresp[1])
    );

    ahb_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .HSEL(hsel && sel == 2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000),
        .HPROT(4'b0011), .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hrdyo[2]),
        .HRDATA(hrdata[2]), .HREADYOUT(hrdyo[2]), .HRESP(hresp[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic out_chk(input string tag, input logic rdy, input logic resp, input logic [31:0] data);
        check_eq({tag, ".rdy"},  {31'b0, hrdyo[sel]}, {31'b0, rdy});
        check_eq({tag, ".resp"}, {31'b0, hresp[sel]}, {31'b0, resp});
        check_eq({tag, ".data"}, hrdata[sel], data);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic ap(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic ap_idle();
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = '0;
    endtask

    initial begin
        reset  = 1'b1;
        hsel   = 1'b1;
        sel    = 0;
        hwdata = '0;
        ap_idle();
        repeat (3) @(posedge clk);
        mid();
        for (int k = 0; k < 3; k++) begin
            sel = k;
            out_chk("reset", 1'b1, 1'b0, 32'h0);
        end
        cyc();
        reset = 1'b0;

        // zero wait states: forwarding, lane writes, error cases, top word
        sel = 0;
        ap(1, 3'b010, 32'h20);        mid(); out_chk("ws0_ap", 1, 0, 32'h0); cyc();
        hwdata = 32'h11223344; ap(1, 3'b000, 32'h21); mid(); out_chk("ws0_wr_word", 1, 0, 32'h0); cyc();
        hwdata = 32'h0000AA00; ap(0, 3'b010, 32'h20); mid(); out_chk("ws0_wr_byte", 1, 0, 32'h0); cyc();
        hwdata = 32'h0;        ap(1, 3'b001, 32'h22); mid(); out_chk("ws0_fwd", 1, 0, 32'h1122AA44); cyc();
        hwdata = 32'hBEEF0000; ap(0, 3'b010, 32'h20); mid(); out_chk("ws0_wr_half", 1, 0, 32'h0); cyc();
        hwdata = 32'h0;        ap(1, 3'b001, 32'h23); mid(); out_chk("ws0_rd_half", 1, 0, 32'hBEEFAA44); cyc();
        ap_idle();             mid(); out_chk("ws0_herr1", 0, 1, 32'h0); cyc();
        ap(1, 3'b010, 32'hFFC); mid(); out_chk("ws0_herr2", 1, 1, 32'h0); cyc();
        hwdata = 32'h5A5A5A5A; ap(0, 3'b010, 32'hFFC); mid(); out_chk("ws0_wr_last", 1, 0, 32'h0); cyc();
        hwdata = 32'h0;        ap(0, 3'b011, 32'h0);   mid(); out_chk("ws0_rd_last", 1, 0, 32'h5A5A5A5A); cyc();
        ap_idle();             mid(); out_chk("ws0_szerr1", 0, 1, 32'h0); cyc();
        ap(0, 3'b010, 32'h20); mid(); out_chk("ws0_szerr2", 1, 1, 32'h0); cyc();
        ap_idle();             mid(); out_chk("ws0_rd_after_err", 1, 0, 32'hBEEFAA44); cyc();

        // one wait state: write/read, misaligned error, out-of-range error
        sel = 1;
        ap(1, 3'b010, 32'h10); mid(); out_chk("ws1_ap", 1, 0, 32'h0); cyc();
        hwdata = 32'hDEADBEEF; ap_idle(); mid(); out_chk("ws1_wr_wait", 0, 0, 32'h0); cyc();
        ap(0, 3'b010, 32'h10); mid(); out_chk("ws1_wr_done", 1, 0, 32'h0); cyc();
        hwdata = 32'h0; ap_idle(); mid(); out_chk("ws1_rd_wait", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws1_rd_done", 1, 0, 32'hDEADBEEF); cyc();

        ap(0, 3'b010, 32'h2);  mid(); out_chk("ws1_ap_mis", 1, 0, 32'h0); cyc();
        ap_idle();             mid(); out_chk("ws1_mis_err1", 0, 1, 32'h0); cyc();
        ap(0, 3'b010, 32'h10); mid(); out_chk("ws1_mis_err2", 1, 1, 32'h0); cyc();
        ap_idle();             mid(); out_chk("ws1_after_mis_wait", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws1_after_mis_done", 1, 0, 32'hDEADBEEF); cyc();

        ap(1, 3'b010, 32'h0); cyc();
        hwdata = 32'hA5A50001; ap_idle(); cyc();
        ap(1, 3'b010, 32'h1000); mid(); out_chk("ws1_wr0_done", 1, 0, 32'h0); cyc();
        hwdata = 32'h12345678; ap_idle(); mid(); out_chk("ws1_oor_err1", 0, 1, 32'h0); cyc();
        ap(0, 3'b010, 32'h0); mid(); out_chk("ws1_oor_err2", 1, 1, 32'h0); cyc();
        ap_idle();            mid(); out_chk("ws1_rd0_wait", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws1_rd0_done", 1, 0, 32'hA5A50001); cyc();

        ap(1, 3'b010, 32'h4); cyc();
        hwdata = 32'h01020304; ap_idle(); cyc();
        cyc();
        hsel = 1'b0; ap(1, 3'b010, 32'h4); mid(); out_chk("ws1_unsel_ap", 1, 0, 32'h0); cyc();
        hwdata = 32'hFFFFFFFF; ap_idle(); mid(); out_chk("ws1_unsel_dp", 1, 0, 32'h0); cyc();
        hsel = 1'b1; ap(0, 3'b010, 32'h4); cyc();
        ap_idle(); mid(); out_chk("ws1_rd4_wait", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws1_rd4_done", 1, 0, 32'h01020304); cyc();

        // three wait states: full-length write, then reset mid-transfer
        sel = 2;
        ap(1, 3'b010, 32'h8); cyc();
        hwdata = 32'h13579BDF; ap_idle();
        mid(); out_chk("ws3_w1", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws3_w2", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws3_w3", 0, 0, 32'h0); cyc();
        mid(); out_chk("ws3_done", 1, 0, 32'h0); cyc();

        ap(1, 3'b010, 32'h8); cyc();
        hwdata = 32'hCAFEF00D; ap_idle(); cyc();
        mid(); out_chk("ws3_rst_pre", 0, 0, 32'h0);
        reset = 1'b1;
        #1;
        out_chk("ws3_async_rst", 1, 0, 32'h0);
        cyc(); cyc();
        reset = 1'b0;
        hwdata = 32'h0;
        ap(0, 3'b010, 32'h8); cyc();
        ap_idle(); cyc(); cyc(); cyc();
        mid(); out_chk("ws3_rd_prior", 1, 0, 32'h13579BDF); cyc();

        sel = 1;
        ap(0, 3'b010, 32'h10); cyc();
        ap_idle(); cyc();
        mid(); out_chk("ws1_mem_kept", 1, 0, 32'hDEADBEEF); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
